// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer behind the UART receiver with status, trigger irq and rts_n hysteresis
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  parameter int RX_TRIG = 8,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          parity_error,
  input  logic          rd_en,
  input  logic          fifo_flush,
  input  logic          ovr_clr,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          irq_rx,
  output logic          rts_n
);
  logic [8:0]    mem [DEPTH];
  logic [8:0]    hold_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rx_done_q, push_req, pop, acc, ovr_set;
  assign rx_empty = level == '0;
  assign rx_full  = level == (AW+1)'(DEPTH);
  assign irq_rx   = level >= (AW+1)'(RX_TRIG);
  assign push_req = rx_done & ~rx_done_q;
  assign pop      = rd_en & ~rx_empty & ~fifo_flush;
  assign acc      = push_req & ~fifo_flush & (~rx_full | pop);
  assign ovr_set  = push_req & ~fifo_flush & rx_full & ~pop;
  assign {rd_perr, rd_data} = rx_empty ? hold_q : mem[rd_ptr];
  // character storage; left uninitialised since the level gates every read
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr] <= {parity_error, rx_data};
  // pointers, level, edge detect, sticky overrun and the held head value shown while empty
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rx_done_q <= 1'b1;
      overrun   <= 1'b0;
      hold_q    <= '0;
    end else begin
      rx_done_q <= rx_done;
      overrun   <= ovr_set | (overrun & ~ovr_clr);
      hold_q    <= rx_empty ? hold_q : mem[rd_ptr];
      wr_ptr    <= fifo_flush ? '0 : wr_ptr + AW'(acc);
      rd_ptr    <= fifo_flush ? '0 : rd_ptr + AW'(pop);
      level     <= fifo_flush ? '0 : level + (AW+1)'(acc) - (AW+1)'(pop);
    end
  // flow control with hysteresis, driven from the registered level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rts_n <= 1'b0;
    else if (level >= (AW+1)'(RTS_HI)) rts_n <= 1'b1;
    else if (level <= (AW+1)'(RTS_LO)) rts_n <= 1'b0;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 0, reset_n = 0;
  logic [7:0] rx_data = 0;
  logic       rx_done = 1, parity_error = 0, rd_en = 0, fifo_flush = 0, ovr_clr = 0;
  logic [7:0] rd_data;
  logic       rd_perr, rx_empty, rx_full, overrun, irq_rx, rts_n;
  logic [4:0] level;
  int         n_chk = 0, n_fail = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .parity_error(parity_error), .rd_en(rd_en), .fifo_flush(fifo_flush),
    .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_perr(rd_perr), .rx_empty(rx_empty),
    .rx_full(rx_full), .level(level), .overrun(overrun), .irq_rx(irq_rx), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe);
    @(negedge clk);
    rx_data = d;
    parity_error = pe;
    rx_done = 0;
    @(negedge clk);
    rx_done = 1;
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_level", level, 0);
    check("rst_ovr", overrun, 0);
    check("rst_irq", irq_rx, 0);
    check("rst_rts", rts_n, 0);
    check("rst_data", {rd_perr, rd_data}, 0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    check("no_spurious_push", level, 0);

    push(8'h41, 0); push(8'h42, 0); push(8'h43, 0);
    check("lvl3", level, 3);
    check("head41", rd_data, 8'h41);
    pop(); check("head42", rd_data, 8'h42);
    pop(); check("head43", rd_data, 8'h43);
    pop();
    check("empty_after_pops", rx_empty, 1);
    check("lvl0", level, 0);
    check("hold_last", rd_data, 8'h43);

    push(8'h5A, 1);
    check("perr1", rd_perr, 1);
    check("data5a", rd_data, 8'h5A);
    pop();
    push(8'h11, 0);
    check("perr0", rd_perr, 0);
    check("data11", rd_data, 8'h11);
    pop();

    for (int i = 0; i < 16; i++) push(8'(i), 0);
    check("full_flag", rx_full, 1);
    check("full_lvl", level, 16);
    check("full_ovr_clear", overrun, 0);
    push(8'hFF, 0);
    check("ovr_set", overrun, 1);
    check("ovr_lvl", level, 16);
    check("ovr_head", rd_data, 8'h00);
    @(negedge clk); ovr_clr = 1;
    @(negedge clk); ovr_clr = 0;
    check("ovr_clr", overrun, 0);

    @(negedge clk); rx_data = 8'hAA; rx_done = 0;
    @(negedge clk); rx_done = 1; rd_en = 1;
    @(negedge clk); rd_en = 0;
    check("full_pushpop_lvl", level, 16);
    check("full_pushpop_ovr", overrun, 0);
    check("full_pushpop_head", rd_data, 8'h01);
    repeat (15) pop();
    check("aa_head", rd_data, 8'hAA);
    check("aa_lvl", level, 1);
    pop();
    check("aa_empty", rx_empty, 1);

    @(negedge clk); rx_data = 8'h66; rx_done = 0;
    @(negedge clk); rx_done = 1; rd_en = 1;
    @(negedge clk); rd_en = 0;
    check("empty_pushpop_lvl", level, 1);
    check("empty_pushpop_head", rd_data, 8'h66);
    pop();

    for (int i = 1; i <= 12; i++) begin
      push(8'(8'h80 + i), 0);
      check($sformatf("up_irq%0d", i), irq_rx, 32'(i >= 8));
      check($sformatf("up_rts%0d", i), rts_n, 0);
    end
    @(negedge clk);
    check("rts_rise", rts_n, 1);
    for (int l = 11; l >= 4; l--) begin
      pop();
      check($sformatf("dn_lvl%0d", l), level, 32'(l));
      check($sformatf("dn_irq%0d", l), irq_rx, 32'(l >= 8));
      check($sformatf("dn_rts%0d", l), rts_n, 1);
    end
    @(negedge clk);
    check("rts_fall", rts_n, 0);

    for (int i = 0; i < 12; i++) push(8'(8'hC0 + i), 0);
    push(8'hEE, 0);
    check("ovr_again", overrun, 1);
    repeat (11) pop();
    check("lvl5", level, 5);
    @(negedge clk); rx_data = 8'h77; rx_done = 0;
    @(negedge clk); rx_done = 1; fifo_flush = 1;
    @(negedge clk); fifo_flush = 0;
    check("flush_lvl", level, 0);
    check("flush_empty", rx_empty, 1);
    check("flush_ovr_kept", overrun, 1);
    check("flush_rts_lag", rts_n, 1);
    @(negedge clk);
    check("flush_rts_low", rts_n, 0);
    pop();
    check("empty_pop_lvl", level, 0);
    check("empty_pop_empty", rx_empty, 1);
    push(8'h33, 0);
    check("post_flush_head", rd_data, 8'h33);
    check("post_flush_lvl", level, 1);

    #3 reset_n = 0;
    #1;
    check("async_rst_lvl", level, 0);
    check("async_rst_ovr", overrun, 0);
    check("async_rst_data", rd_data, 0);
    @(negedge clk); reset_n = 1;
    repeat (2) @(negedge clk);
    check("post_rst_lvl", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver.
- Captures each completed character (data byte plus parity-error flag) on the receiver's completion signal.
- Stores characters in a first-word-fall-through FIFO that the APB register block pops.
- Provides level/status flags and an RX trigger interrupt.
- Drives hardware flow control (rts_n) from the fill level with hysteresis.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
AW, $clog2(DEPTH), pointer width (derived, not overridden)
RX_TRIG, 8, irq_rx asserts when level >= RX_TRIG (1..DEPTH)
RTS_HI, 12, rts_n deasserts (goes 1) when level >= RTS_HI
RTS_LO, 4, rts_n reasserts (goes 0) when level <= RTS_LO; RTS_LO < RTS_HI

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_data  input  8  received character from receiver, stable while rx_done rises
rx_done  input  1  receiver completion level; a 0->1 transition marks one new character
parity_error  input  1  receiver parity flag, sampled with rx_data
rd_en  input  1  APB pop request, one entry per cycle high
fifo_flush  input  1  synchronous clear of FIFO contents
ovr_clr  input  1  clears sticky overrun flag
rd_data  output  8  head-of-FIFO data (valid when rx_empty=0)
rd_perr  output  1  parity flag of head entry
rx_empty  output  1  level == 0
rx_full  output  1  level == DEPTH
level  output  AW+1  current entry count, 0..DEPTH
overrun  output  1  sticky: a character was dropped because the FIFO was full
irq_rx  output  1  level >= RX_TRIG
rts_n  output  1  flow control to remote transmitter; 0 = ready to receive

Behaviour:
- Reset (async, reset_n=0):
  - Pointers and level = 0; rx_empty=1, rx_full=0, overrun=0, irq_rx=0, rts_n=0, rd_data=0, rd_perr=0.
  - rx_done_q (edge-detect register) resets to 1, because the receiver holds rx_done high when idle. No push after reset release until rx_done has gone low and then high again.
- Push detect: push_req = rx_done & ~rx_done_q, evaluated every cycle; rx_done_q <= rx_done.
- Write:
  - On push_req and accepted, {parity_error, rx_data} is written at wr_ptr at that clock edge.
  - wr_ptr increments modulo DEPTH.
  - level, rx_empty and rx_full reflect the new entry from the following cycle.
- Read:
  - FWFT: rd_data and rd_perr show the entry at rd_ptr whenever rx_empty=0. They are driven from registered storage and pointers, with no extra latency.
  - rd_en=1 with rx_empty=0 pops the entry: rd_ptr increments modulo DEPTH and the next entry appears the following cycle.
  - rd_en while empty is ignored: no pointer change, no error flag.
  - rd_data holds its last value when empty.
- Level arithmetic:
  - push only: +1; pop only: -1; push and pop together: unchanged. Both pointers still advance.
  - level never exceeds DEPTH or goes below 0.
- Boundary conditions:
  - Full, push, no pop: character dropped, pointers and level unchanged, overrun <= 1 (sticky).
  - Full, push, and rd_en in the same cycle: both succeed, level stays DEPTH, no overrun.
  - Empty, push, and rd_en in the same cycle: pop ignored, push succeeds, level = 1.
  - ovr_clr: overrun <= 0. If an overrun event occurs in the same cycle, set wins.
  - fifo_flush:
    - pointers and level <= 0 at that edge; a simultaneous push or pop is discarded, and the discarded push does not set overrun.
    - overrun is not affected.
    - rx_done_q still updates normally.
  - Pointer wrap-around is at DEPTH-1 -> 0. Full/empty are derived only from level, never from pointer equality.
- irq_rx: combinational from the level register (level >= RX_TRIG).
- rts_n (registered, hysteresis):
  - if level >= RTS_HI, rts_n <= 1; else if level <= RTS_LO, rts_n <= 0; else hold.
  - Uses the registered level, so rts_n lags level by one cycle.
  - Flush drives level to 0, so rts_n returns to 0 one cycle after the flush takes effect.
- Reset asserted mid-operation: all state returns to reset values immediately. Storage contents need not be cleared.

Test Plan:
- Reset release with rx_done held 1, then 3 low->high pulses carrying 0x41, 0x42, 0x43 (perr=0) -> no spurious push at reset release; level=3, rd_data=0x41. Three single-cycle rd_en yield 0x42, 0x43 in turn, then rx_empty=1, level=0.
- Push 0x5A with parity_error=1 -> rd_perr=1 at head; pop, then push 0x11 perr=0 -> rd_perr=0, rd_data=0x11.
- Fill 16 entries (0x00..0x0F), then push 0xFF -> rx_full=1, overrun=1, level=16, head still 0x00. Pulse ovr_clr -> overrun=0.
- With the FIFO full, apply push 0xAA and rd_en in the same cycle -> level stays 16, overrun=0. After 15 more pops, rd_data=0xAA.
- Push entries one per character -> irq_rx rises when level reaches 8; rts_n rises one cycle after level reaches 12. Pop down -> rts_n stays 1 at levels 11..5 and returns to 0 one cycle after level reaches 4.
- With level=5 and overrun=1, pulse fifo_flush coincident with a push edge -> level=0, rx_empty=1, overrun stays 1, pushed byte discarded. rd_en on the empty FIFO -> no change.
